// File: rtl/ibus_sync_xfer_if.sv
// Core-request and system-bus signal bundle for ibus_sync_xfer.
// master = core + system-bus environment, slave = the transfer block.
interface ibus_sync_xfer_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          core_req;
  logic          core_wr;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_busy;
  logic          core_ack;
  logic [DW-1:0] core_rdata;
  logic          core_err;

  logic          bus_req;
  logic          bus_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output core_req, core_wr, core_addr, core_wdata, bus_ack, bus_rdata,
    input  core_busy, core_ack, core_rdata, core_err,
    input  bus_req, bus_wr, bus_addr, bus_wdata
  );

  modport slave (
    input  core_req, core_wr, core_addr, core_wdata, bus_ack, bus_rdata,
    output core_busy, core_ack, core_rdata, core_err,
    output bus_req, bus_wr, bus_addr, bus_wdata
  );
endinterface

// File: rtl/ibus_sync_xfer.sv
// Launches one core request onto the clk_system-timed bus on sync-qualified edges.
// Define IBUS_SYNC_TIMEOUT_EN to abort transfers after TIMEOUT_SYNCS unanswered syncs.
module ibus_sync_xfer #(
  parameter int AW            = 24,
  parameter int DW            = 32,
  parameter int TIMEOUT_SYNCS = 255
) (
  input  logic             clk_ungated,
  input  logic             rst_a,
  input  logic             sync,
  ibus_sync_xfer_if.slave  bif
);

  if (TIMEOUT_SYNCS < 1 || TIMEOUT_SYNCS > 255) begin : g_bad_timeout
    $error("TIMEOUT_SYNCS must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, PEND, ACTIVE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          hold_wr;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          capture;
  logic          launch_core;
  logic          launch_hold;
  logic          done_ok;
  logic          done_to;
  logic          to_hit;

`ifdef IBUS_SYNC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_SYNCS - 1);

  logic [7:0] to_cnt;
  logic       err_q;

  // to_cnt counts unanswered syncs already seen, so this sync is the last allowed one.
  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk_ungated) begin
    if (!rst_a) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (launch_core || launch_hold)
        to_cnt <= '0;
      else if (state == ACTIVE && sync && !bif.bus_ack)
        to_cnt <= to_cnt + 8'd1;
      if (done_ok)
        err_q <= 1'b0;
      else if (done_to)
        err_q <= 1'b1;
    end
  end

  assign bif.core_err = err_q;
`else
  assign to_hit       = 1'b0;
  assign bif.core_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_ungated) begin
    if (!rst_a) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bif.core_req) state_nxt = sync ? ACTIVE : PEND;
      PEND:    if (sync) state_nxt = ACTIVE;
      ACTIVE:  if (sync && (bif.bus_ack || to_hit)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ACTIVE is only entered on a launch sync, so its first sync is already the next one.
  always_comb begin
    capture     = 1'b0;
    launch_core = 1'b0;
    launch_hold = 1'b0;
    done_ok     = 1'b0;
    done_to     = 1'b0;
    case (state)
      IDLE: begin
        capture     = bif.core_req;
        launch_core = bif.core_req && sync;
      end
      PEND:   launch_hold = sync;
      ACTIVE: begin
        done_ok = sync && bif.bus_ack;
        done_to = sync && !bif.bus_ack && to_hit;
      end
      default: ;
    endcase
  end

  assign bif.core_busy = (state != IDLE);

  // NOTE: hold registers are plain flops, not a memory array, so they are
  // reset along with everything else.
  always_ff @(posedge clk_ungated) begin
    if (!rst_a) begin
      hold_wr        <= 1'b0;
      hold_addr      <= '0;
      hold_wdata     <= '0;
      bif.bus_req    <= 1'b0;
      bif.bus_wr     <= 1'b0;
      bif.bus_addr   <= '0;
      bif.bus_wdata  <= '0;
      bif.core_ack   <= 1'b0;
      bif.core_rdata <= '0;
    end else begin
      bif.core_ack <= done_ok || done_to;
      if (capture) begin
        hold_wr    <= bif.core_wr;
        hold_addr  <= bif.core_addr;
        hold_wdata <= bif.core_wdata;
      end
      if (launch_core) begin
        bif.bus_req   <= 1'b1;
        bif.bus_wr    <= bif.core_wr;
        bif.bus_addr  <= bif.core_addr;
        bif.bus_wdata <= bif.core_wdata;
      end else if (launch_hold) begin
        bif.bus_req   <= 1'b1;
        bif.bus_wr    <= hold_wr;
        bif.bus_addr  <= hold_addr;
        bif.bus_wdata <= hold_wdata;
      end else if (done_ok || done_to) begin
        bif.bus_req <= 1'b0;
      end
      if (done_ok) bif.core_rdata <= bif.bus_rdata;
    end
  end

endmodule

// File: tb/tb_ibus_sync_xfer.sv
// Self-checking bench for ibus_sync_xfer: transaction-level model compared every
// cycle, plus directed latency/value expectations from the test plan.
module tb_ibus_sync_xfer;
  localparam int AW = 24;
  localparam int DW = 32;
`ifdef IBUS_SYNC_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk_ungated = 1'b0;
  logic rst_a       = 1'b0;
  logic sync        = 1'b0;

  always #5 clk_ungated = ~clk_ungated;

  ibus_sync_xfer_if #(.AW(AW), .DW(DW)) bif ();

  ibus_sync_xfer #(.AW(AW), .DW(DW), .TIMEOUT_SYNCS(TO)) dut (
    .clk_ungated (clk_ungated),
    .rst_a       (rst_a),
    .sync        (sync),
    .bif         (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, launched on the first
  // sync at or after acceptance, answered on a later sync.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          m_txn;
  logic          m_busy = 0, m_launched = 0;
  int            m_syncs = 0;
  logic          e_req = 0, e_wr = 0, e_ack = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;

  always @(posedge clk_ungated) begin : model
    txn_t          t;
    logic          busy, launched, was_busy, req, wr, ack, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    int            syncs;
    t = m_txn; busy = m_busy; launched = m_launched; syncs = m_syncs;
    req = e_req; wr = e_wr; addr = e_addr; wdata = e_wdata; rdata = e_rdata; err = e_err;
    ack = 1'b0;
    if (!rst_a) begin
      t = '{1'b0, '0, '0}; busy = 0; launched = 0; syncs = 0;
      req = 0; wr = 0; addr = '0; wdata = '0; rdata = '0; err = 0;
    end else begin
      was_busy = busy;
      if (busy && launched && sync) begin
        if (bif.bus_ack) begin
          req = 0; rdata = bif.bus_rdata; ack = 1; err = 0; busy = 0;
        end else begin
          syncs++;
`ifdef IBUS_SYNC_TIMEOUT_EN
          if (syncs == TO) begin
            req = 0; ack = 1; err = 1; busy = 0;
          end
`endif
        end
      end
      if (!was_busy && bif.core_req) begin
        busy = 1; launched = 0;
        t = '{bif.core_wr, bif.core_addr, bif.core_wdata};
      end
      if (busy && !launched && sync) begin
        req = 1; wr = t.wr; addr = t.addr; wdata = t.wdata;
        launched = 1; syncs = 0;
      end
    end
    m_txn <= t; m_busy <= busy; m_launched <= launched; m_syncs <= syncs;
    e_req <= req; e_wr <= wr; e_addr <= addr; e_wdata <= wdata;
    e_ack <= ack; e_err <= err; e_rdata <= rdata;
  end

  bit cmp_en = 0;

  always @(negedge clk_ungated) begin
    if (cmp_en) begin
      check("core_busy",  bif.core_busy,  m_busy);
      check("core_ack",   bif.core_ack,   e_ack);
      check("core_err",   bif.core_err,   e_err);
      check("core_rdata", bif.core_rdata, e_rdata);
      check("bus_req",    bif.bus_req,    e_req);
      check("bus_wr",     bif.bus_wr,     e_wr);
      check("bus_addr",   bif.bus_addr,   e_addr);
      check("bus_wdata",  bif.bus_wdata,  e_wdata);
    end
  end

  // Sync generator: one pulse every `ratio` cycles; align() makes the next cycle a sync.
  int ratio = 3;
  int ph    = 0;
  int seen_200 = 0;

  task automatic align(input int r);
    ratio = r;
    ph    = r - 1;
  endtask

  task automatic tick();
    @(negedge clk_ungated);
    bif.core_req = 1'b0;
    ph   = (ph + 1 >= ratio) ? 0 : ph + 1;
    sync = (ph == 0);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bif.core_req   = 1'b1;
    bif.core_wr    = wr;
    bif.core_addr  = addr;
    bif.core_wdata = wdata;
  endtask

  // Cycle n is counted from the request cycle; latencies stay -1 if never seen.
  task automatic run_xfer(input int ack_from, input int dup_at, output int req_lat, output int ack_lat);
    req_lat = -1;
    ack_lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == ack_from) bif.bus_ack = 1'b1;
      if (n == dup_at) issue(1'b0, 24'h000200, 32'h0);
      if (bif.bus_addr == 24'h000200) seen_200++;
      if (bif.bus_req && req_lat < 0) req_lat = n;
      if (bif.core_ack) begin
        ack_lat = n;
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rl, al, extra;

  initial begin
    bif.core_req = 0; bif.core_wr = 0; bif.core_addr = '0; bif.core_wdata = '0;
    bif.bus_ack = 0; bif.bus_rdata = '0;
    align(3);
    tick();
    cmp_en = 1;
    repeat (2) tick();
    check("rst_busy",    bif.core_busy,  0);
    check("rst_bus_req", bif.bus_req,    0);
    check("rst_rdata",   bif.core_rdata, 0);
    rst_a = 1'b1;
    tick();

    // 1:3 read issued one cycle after a sync
    align(3);
    tick();
    tick();
    issue(1'b0, 24'h000100, 32'h0);
    bif.bus_rdata = 32'hDEADBEEF;
    run_xfer(3, -1, rl, al);
    check("t1_req_lat", rl, 3);
    check("t1_ack_lat", al, 6);
    check("t1_rdata",   bif.core_rdata, 32'hDEADBEEF);
    check("t1_err",     bif.core_err,   0);
    bif.bus_ack = 0;

    // 1:2 write coincident with sync, ack after 2 syncs, ignored second request
    align(2);
    tick();
    issue(1'b1, 24'h00ABCD, 32'h12345678);
    bif.bus_rdata = 32'hCAFEF00D;
    seen_200 = 0;
    run_xfer(3, 1, rl, al);
    check("t2_req_lat", rl, 1);
    check("t2_ack_lat", al, 5);
    check("t2_bus_req_low", bif.bus_req, 0);
    bif.bus_ack = 0;
    extra = 0;
    repeat (6) begin
      tick();
      if (bif.core_ack) extra++;
      if (bif.bus_addr == 24'h000200) seen_200++;
    end
    check("t3_ack_count", 1 + extra, 1);
    check("t3_no_addr_200", seen_200, 0);
    check("t2_addr_kept",  bif.bus_addr,  24'h00ABCD);
    check("t2_wdata_kept", bif.bus_wdata, 32'h12345678);
    check("t2_wr_kept",    bif.bus_wr,    1);
    check("t2_rdata_wr",   bif.core_rdata, 32'hCAFEF00D);

    // bus_ack already high at the launch sync is not taken
    align(3);
    bif.bus_ack = 1; bif.bus_rdata = 32'h0BADC0DE;
    tick();
    issue(1'b0, 24'h000300, 32'h0);
    run_xfer(-1, -1, rl, al);
    check("t4_req_lat", rl, 1);
    check("t4_ack_lat", al, 4);
    check("t4_rdata",   bif.core_rdata, 32'h0BADC0DE);

    // 1:1 ratio, then a request in the ack cycle
    align(1);
    bif.bus_rdata = 32'h11111111;
    tick();
    issue(1'b0, 24'h000400, 32'h0);
    run_xfer(-1, -1, rl, al);
    check("r1_ack_lat", al, 2);
    issue(1'b0, 24'h000500, 32'h0);
    bif.bus_rdata = 32'h22222222;
    run_xfer(-1, -1, rl, al);
    check("r1_b2b_lat",  al, 2);
    check("r1_b2b_data", bif.core_rdata, 32'h22222222);
    bif.bus_ack = 0;

    // reset while ACTIVE on a non-sync cycle
    align(3);
    tick();
    issue(1'b1, 24'h000600, 32'hAA55AA55);
    tick();
    check("t5_active", bif.bus_req, 1);
    rst_a = 1'b0;
    tick();
    check("t5_bus_req", bif.bus_req,   0);
    check("t5_busy",    bif.core_busy, 0);
    check("t5_ack",     bif.core_ack,  0);
    check("t5_addr",    bif.bus_addr,  0);
    rst_a = 1'b1;
    bif.bus_ack = 1; bif.bus_rdata = 32'h5A5A5A5A;
    issue(1'b0, 24'h000700, 32'h0);
    run_xfer(-1, -1, rl, al);
    check("t5_req_lat", rl, 2);
    check("t5_ack_lat", al, 5);
    check("t5_rdata",   bif.core_rdata, 32'h5A5A5A5A);
    bif.bus_ack = 0;

`ifdef IBUS_SYNC_TIMEOUT_EN
    // stuck bus_ack aborts on the 4th sync after launch
    align(2);
    tick();
    issue(1'b0, 24'h000800, 32'h0);
    bif.bus_rdata = 32'h66666666;
    run_xfer(-1, -1, rl, al);
    check("to_ack_lat", al, 9);
    check("to_err",     bif.core_err,   1);
    check("to_rdata",   bif.core_rdata, 32'h5A5A5A5A);
    check("to_bus_req", bif.bus_req,    0);
    // ack on the 4th sync wins
    align(2);
    tick();
    issue(1'b0, 24'h000900, 32'h0);
    bif.bus_rdata = 32'h77777777;
    run_xfer(8, -1, rl, al);
    check("to_win_lat",   al, 9);
    check("to_win_err",   bif.core_err,   0);
    check("to_win_rdata", bif.core_rdata, 32'h77777777);
    bif.bus_ack = 0;
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
